// File: rtl/mux_frame_deser.sv
// Serial-to-parallel frame assembler. Each cycle it takes one bit per channel, and it
// hands out complete frames through a single holding register over a valid/ready handshake.
module mux_frame_deser #(
  parameter int CH    = 70,
  parameter int FRAME = 196
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_vld,
  input  logic                  sync,
  input  logic [CH-1:0]         din,
  input  logic                  frame_rdy,
  output logic                  frame_vld,
  output logic [CH*FRAME-1:0]   frame_data,
  output logic [CH-1:0]         const_flag,
  output logic                  overflow,
  output logic                  sync_err,
  input  logic                  clr_err
);

  localparam int CW  = $clog2(FRAME);
  localparam int CIW = (CH > 1) ? $clog2(CH) : 1;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [CH-1:0][FRAME-1:0] buf_q, buf_d;
  logic [CH-1:0][FRAME-1:0] hold_q, hold_d;
  logic                     vld_q, vld_d;
  logic [CH-1:0]            cflag_q, cflag_d;
  logic                     ovf_q, ovf_d;
  logic                     serr_q, serr_d;

  logic                     wr_en;
  logic [CW-1:0]            wr_idx;
  logic                     complete;
  logic                     xfer;
  logic                     serr_set;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    buf_d    = buf_q;
    hold_d   = hold_q;
    vld_d    = vld_q;
    cflag_d  = cflag_q;
    wr_en    = 1'b0;
    wr_idx   = '0;
    complete = 1'b0;
    serr_set = 1'b0;

    // sync always wins: it restarts at bit 0 even on what would be the completing beat
    if (din_vld) begin
      if (sync) begin
        wr_en    = 1'b1;
        wr_idx   = '0;
        cnt_d    = CW'(1);
        state_d  = COLLECT;
        serr_set = (state_q == COLLECT);
      end else if (state_q == COLLECT) begin
        wr_en  = 1'b1;
        wr_idx = cnt_q;
        if (cnt_q == CW'(FRAME - 1)) begin
          complete = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    if (wr_en) begin
      for (int unsigned i = 0; i < CH; i++) begin
        buf_d[CIW'(i)][wr_idx] = din[CIW'(i)];
      end
    end

    // buf_d already contains the completing bit, so flags cover the whole frame
    xfer = complete && (!vld_q || frame_rdy);
    if (xfer) begin
      hold_d = buf_d;
      vld_d  = 1'b1;
      for (int unsigned i = 0; i < CH; i++) begin
        cflag_d[CIW'(i)] = (~|buf_d[CIW'(i)]) ^ (&buf_d[CIW'(i)]);
      end
    end else if (vld_q && frame_rdy) begin
      vld_d = 1'b0;
    end

    ovf_d  = (ovf_q && !clr_err) || (complete && !xfer);
    serr_d = (serr_q && !clr_err) || serr_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
      hold_q  <= '0;
      vld_q   <= 1'b0;
      cflag_q <= '0;
      ovf_q   <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      hold_q  <= hold_d;
      vld_q   <= vld_d;
      cflag_q <= cflag_d;
      ovf_q   <= ovf_d;
      serr_q  <= serr_d;
    end
  end

  assign frame_vld  = vld_q;
  assign frame_data = hold_q;
  assign const_flag = cflag_q;
  assign overflow   = ovf_q;
  assign sync_err   = serr_q;

endmodule

// File: tb/tb_mux_frame_deser.sv
// Directed bench for mux_frame_deser: framing, constant flags, backpressure, sync errors, reset.
module tb_mux_frame_deser;

  localparam int CH    = 70;
  localparam int FRAME = 196;
  localparam int W     = CH * FRAME;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din_vld = 1'b0;
  logic          sync = 1'b0;
  logic [CH-1:0] din = '0;
  logic          frame_rdy = 1'b0;
  logic          clr_err = 1'b0;
  logic          frame_vld;
  logic [W-1:0]  frame_data;
  logic [CH-1:0] const_flag;
  logic          overflow;
  logic          sync_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [W-1:0]  exp_a, exp_b, exp_c;
  logic [CH-1:0] exp_const;

  mux_frame_deser #(.CH(CH), .FRAME(FRAME)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_vld    (din_vld),
    .sync       (sync),
    .din        (din),
    .frame_rdy  (frame_rdy),
    .frame_vld  (frame_vld),
    .frame_data (frame_data),
    .const_flag (const_flag),
    .overflow   (overflow),
    .sync_err   (sync_err),
    .clr_err    (clr_err)
  );

  always #5 clk = ~clk;

  // pattern 0: (i+k)&1, pattern 1: ch0 ones / ch1 zeros / rest alternating, pattern 2: inverted 0
  function automatic logic gb(int pat, int i, int k);
    if (pat == 1 && i == 0) return 1'b1;
    if (pat == 1 && i == 1) return 1'b0;
    if (pat == 2) return ((i + k + 1) % 2) == 1;
    return ((i + k) % 2) == 1;
  endfunction

  function automatic logic [W-1:0] mk(int pat);
    logic [W-1:0] e;
    e = '0;
    for (int i = 0; i < CH; i++)
      for (int k = 0; k < FRAME; k++)
        e[i*FRAME + k] = gb(pat, i, k);
    return e;
  endfunction

  task automatic chk1(string tag, logic obs, logic exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chkc(string tag, logic [CH-1:0] obs, logic [CH-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chkd(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed data differs from expected in %0d bits", tag, $countones(obs ^ exp));
  endtask

  // Bits k = from .. from+n-1 of a pattern; sync accompanies bit 0 only.
  task automatic beats(int pat, int from, int n);
    for (int k = from; k < from + n; k++) begin
      din_vld = 1'b1;
      sync    = (k == 0);
      for (int i = 0; i < CH; i++) din[i] = gb(pat, i, k);
      @(posedge clk); #1;
    end
    din_vld = 1'b0;
    sync    = 1'b0;
  endtask

  task automatic idle(int n, logic junk);
    for (int c = 0; c < n; c++) begin
      din_vld = 1'b0;
      sync    = junk;
      for (int i = 0; i < CH; i++) din[i] = junk ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
    end
    sync = 1'b0;
  endtask

  initial begin
    exp_a = mk(0);
    exp_b = mk(2);
    exp_c = mk(1);
    exp_const = '0;
    exp_const[0] = 1'b1;
    exp_const[1] = 1'b1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_vld", frame_vld, 1'b0);
    chkd("rst_data", frame_data, '0);
    chkc("rst_const", const_flag, '0);
    chk1("rst_ovf", overflow, 1'b0);
    chk1("rst_serr", sync_err, 1'b0);
    rst = 1'b0;

    // basic frame with one-cycle output pulse
    frame_rdy = 1'b1;
    beats(0, 0, FRAME - 1);
    chk1("basic_vld_early", frame_vld, 1'b0);
    beats(0, FRAME - 1, 1);
    chk1("basic_vld", frame_vld, 1'b1);
    chkd("basic_data", frame_data, exp_a);
    chkc("basic_const", const_flag, '0);
    chk1("basic_ovf", overflow, 1'b0);
    chk1("basic_serr", sync_err, 1'b0);
    idle(1, 1'b0);
    chk1("basic_vld_drop", frame_vld, 1'b0);

    // constant detection
    beats(1, 0, FRAME);
    chk1("const_vld", frame_vld, 1'b1);
    chkd("const_data", frame_data, exp_c);
    chkc("const_flag", const_flag, exp_const);
    idle(1, 1'b0);

    // backpressure and overflow
    frame_rdy = 1'b0;
    beats(0, 0, FRAME);
    chk1("bp_vld_a", frame_vld, 1'b1);
    chk1("bp_ovf_pre", overflow, 1'b0);
    beats(2, 0, FRAME);
    chk1("bp_ovf", overflow, 1'b1);
    chk1("bp_vld_held", frame_vld, 1'b1);
    chkd("bp_data_held", frame_data, exp_a);
    frame_rdy = 1'b1;
    idle(1, 1'b0);
    chk1("bp_vld_drain", frame_vld, 1'b0);
    chkd("bp_data_after", frame_data, exp_a);
    chk1("bp_ovf_sticky", overflow, 1'b1);
    clr_err = 1'b1;
    idle(1, 1'b0);
    clr_err = 1'b0;
    chk1("bp_ovf_clr", overflow, 1'b0);

    // drain and completion in the same cycle
    frame_rdy = 1'b0;
    beats(0, 0, FRAME);
    beats(2, 0, FRAME - 1);
    chkd("sim_data_a", frame_data, exp_a);
    frame_rdy = 1'b1;
    beats(2, FRAME - 1, 1);
    chk1("sim_vld", frame_vld, 1'b1);
    chkd("sim_data_b", frame_data, exp_b);
    chk1("sim_ovf", overflow, 1'b0);
    idle(1, 1'b0);
    chk1("sim_vld_drop", frame_vld, 1'b0);

    // early sync with gaps; gap cycles carry junk that must be ignored
    beats(0, 0, 50);
    idle(3, 1'b1);
    beats(0, 50, 50);
    chk1("es_serr_pre", sync_err, 1'b0);
    beats(2, 0, 1);
    chk1("es_serr", sync_err, 1'b1);
    beats(2, 1, 99);
    idle(3, 1'b1);
    beats(2, 100, FRAME - 101);
    chk1("es_vld_early", frame_vld, 1'b0);
    beats(2, FRAME - 1, 1);
    chk1("es_vld", frame_vld, 1'b1);
    chkd("es_data", frame_data, exp_b);
    chk1("es_serr_sticky", sync_err, 1'b1);
    clr_err = 1'b1;
    idle(1, 1'b0);
    clr_err = 1'b0;
    chk1("es_serr_clr", sync_err, 1'b0);

    // reset mid-frame with a held frame
    frame_rdy = 1'b0;
    beats(0, 0, FRAME);
    beats(2, 0, 50);
    chk1("rm_vld_pre", frame_vld, 1'b1);
    rst = 1'b1;
    #1;
    chk1("rm_vld", frame_vld, 1'b0);
    chkd("rm_data", frame_data, '0);
    chkc("rm_const", const_flag, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    frame_rdy = 1'b1;
    beats(0, 1, FRAME);
    chk1("rm_nosync_vld", frame_vld, 1'b0);
    beats(2, 0, FRAME);
    chk1("rm_sync_vld", frame_vld, 1'b1);
    chkd("rm_sync_data", frame_data, exp_b);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
